// File: rtl/ifq_line_ctrl_if.sv
// Handshake bundle for ifq_line_ctrl: fetch-side line input, line-buffer (mem) port, decode-side word output.
// master = controller side, slave = environment (fetch, mem, decode).
interface ifq_line_ctrl_if #(
    parameter int unsigned LINE_W = 128,
    parameter int unsigned WORD_W = 32,
    parameter int unsigned PTR_W  = 2
);
    logic              line_valid;
    logic              line_ready;
    logic [PTR_W-1:0]  mem_Wrp;
    logic              mem_Wr_en;
    logic [PTR_W-1:0]  mem_Rdp;
    logic [LINE_W-1:0] mem_dataOut;
    logic              flush;
    logic [1:0]        flush_offset;
    logic [WORD_W-1:0] instr;
    logic              instr_valid;
    logic              instr_ready;
    logic [PTR_W:0]    level;

    modport master (
        input  line_valid, mem_dataOut, flush, flush_offset, instr_ready,
        output line_ready, mem_Wrp, mem_Wr_en, mem_Rdp, instr, instr_valid, level
    );

    modport slave (
        output line_valid, mem_dataOut, flush, flush_offset, instr_ready,
        input  line_ready, mem_Wrp, mem_Wr_en, mem_Rdp, instr, instr_valid, level
    );
endinterface

// File: rtl/ifq_line_ctrl.sv
// Instruction fetch queue controller over a 4 x 128-bit line buffer; unpacks lines into 32-bit words.
// Optional macro IFQ_SAMECYCLE_EN: lets a full queue accept a line in the cycle its head line retires.
module ifq_line_ctrl #(
    parameter int unsigned LINE_W = 128,
    parameter int unsigned WORD_W = 32,
    parameter int unsigned PTR_W  = 2
) (
    input  logic          clk,
    input  logic          reset,
    ifq_line_ctrl_if.master bus
);
    localparam int unsigned WORDS = LINE_W / WORD_W;

    logic [PTR_W:0]    wr_ptr;
    logic [PTR_W:0]    rd_ptr;
    logic [1:0]        word_idx;
    logic [1:0]        start_idx;

    logic              empty;
    logic              full;
    logic              pop;
    logic              last_word;
    logic              accept;
    logic [WORD_W-1:0] words [WORDS];

    // Slice the head line into words; word 0 is the least significant.
    for (genvar g = 0; g < WORDS; g++) begin : g_words
        assign words[g] = bus.mem_dataOut[g*WORD_W +: WORD_W];
    end

    always_comb begin
        empty     = (wr_ptr == rd_ptr);
        full      = (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]) && (wr_ptr[PTR_W] != rd_ptr[PTR_W]);
        pop       = !empty && bus.instr_ready;
        last_word = (word_idx == 2'd3);
`ifdef IFQ_SAMECYCLE_EN
        bus.line_ready = (!full || (pop && last_word)) && !bus.flush;
`else
        bus.line_ready = !full && !bus.flush;
`endif
        accept          = bus.line_valid && bus.line_ready;
        bus.mem_Wr_en   = accept;
        bus.mem_Wrp     = wr_ptr[PTR_W-1:0];
        bus.mem_Rdp     = rd_ptr[PTR_W-1:0];
        bus.instr       = words[word_idx];
        bus.instr_valid = !empty;
        bus.level       = wr_ptr - rd_ptr;
    end

    // Flush overrides any same-cycle write or pop and re-seeds the word offset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            word_idx  <= 2'd0;
            start_idx <= 2'd0;
        end else if (bus.flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            word_idx  <= bus.flush_offset;
            start_idx <= bus.flush_offset;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + (PTR_W+1)'(1);
            end
            if (pop) begin
                if (last_word) begin
                    word_idx  <= 2'd0;
                    rd_ptr    <= rd_ptr + (PTR_W+1)'(1);
                    start_idx <= 2'd0;
                end else begin
                    word_idx  <= word_idx + 2'd1;
                end
            end
        end
    end

    // The word cursor never falls below the head line's starting offset.
    assert property (@(posedge clk) disable iff (reset) word_idx >= start_idx);

endmodule

// File: tb/tb_ifq_line_ctrl.sv
// Self-checking bench for ifq_line_ctrl: behavioural line buffer plus a word scoreboard.
module tb_ifq_line_ctrl;
    localparam int unsigned LINE_W = 128;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned PTR_W  = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ifq_line_ctrl_if #(.LINE_W(LINE_W), .WORD_W(WORD_W), .PTR_W(PTR_W)) bus ();
    ifq_line_ctrl #(.LINE_W(LINE_W), .WORD_W(WORD_W), .PTR_W(PTR_W)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    logic [LINE_W-1:0] mem_arr [4];
    logic [LINE_W-1:0] line_data;
    always @(posedge clk) if (bus.mem_Wr_en) mem_arr[bus.mem_Wrp] <= line_data;
    assign bus.mem_dataOut = mem_arr[bus.mem_Rdp];

    int vectors;
    int miscompares;
    logic [WORD_W-1:0] sb [$];
    logic [WORD_W-1:0] sb_exp;
    int skip;

    // Scoreboard: words pushed when a line is accepted, popped when the consumer takes one.
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.flush) begin
                sb.delete();
                skip = int'(bus.flush_offset);
            end else begin
                if (bus.instr_valid && bus.instr_ready) begin
                    vectors++;
                    if (sb.size() == 0) begin
                        miscompares++;
                        $display("FAIL sb_underflow: got instr=%h, want no pop (nothing expected)", bus.instr);
                    end else begin
                        sb_exp = sb.pop_front();
                        if (bus.instr !== sb_exp) begin
                            miscompares++;
                            $display("FAIL sb_instr: got %h want %h", bus.instr, sb_exp);
                        end
                    end
                end
                if (bus.mem_Wr_en) begin
                    for (int w = skip; w < 4; w++) sb.push_back(line_data[w*WORD_W +: WORD_W]);
                    skip = 0;
                end
            end
        end
    end

    function automatic logic [LINE_W-1:0] mkline(input logic [WORD_W-1:0] b);
        return {b + 32'd3, b + 32'd2, b + 32'd1, b};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; bus.line_valid = 1'b0; bus.flush = 1'b0; bus.flush_offset = 2'd0;
        bus.instr_ready = 1'b0; line_data = '0;
        sb.delete(); skip = 0;
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic fill4(input logic [WORD_W-1:0] base);
        bus.instr_ready = 1'b0;
        bus.line_valid  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            line_data = mkline(base + 32'(4 * k));
            tick();
        end
        bus.line_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        bus.instr_ready = 1'b1; bus.line_valid = 1'b0; bus.flush = 1'b0;
        for (int i = 0; i < 40; i++) if (bus.instr_valid) tick();
        vectors++; if (bus.instr_valid !== 1'b0) begin miscompares++; $display("FAIL %s_drain_valid: got %b want 0", tag, bus.instr_valid); end
        vectors++; if (bus.level !== 3'd0) begin miscompares++; $display("FAIL %s_drain_level: got %0d want 0", tag, bus.level); end
        vectors++; if (sb.size() != 0) begin miscompares++; $display("FAIL %s_drain_sb: got %0d left want 0", tag, sb.size()); end
    endtask

    task automatic test_reset();
        reset = 1'b1; bus.line_valid = 1'b0; bus.flush = 1'b0; bus.flush_offset = 2'd0;
        bus.instr_ready = 1'b0; line_data = '0; skip = 0;
        #1;
        vectors++; if (bus.line_ready !== 1'b1) begin miscompares++; $display("FAIL reset_line_ready: got %b want 1", bus.line_ready); end
        vectors++; if (bus.mem_Wr_en !== 1'b0) begin miscompares++; $display("FAIL reset_wr_en: got %b want 0", bus.mem_Wr_en); end
        vectors++; if (bus.instr_valid !== 1'b0) begin miscompares++; $display("FAIL reset_instr_valid: got %b want 0", bus.instr_valid); end
        vectors++; if (bus.level !== 3'd0) begin miscompares++; $display("FAIL reset_level: got %0d want 0", bus.level); end
        vectors++; if (bus.mem_Wrp !== 2'd0) begin miscompares++; $display("FAIL reset_wrp: got %0d want 0", bus.mem_Wrp); end
        vectors++; if (bus.mem_Rdp !== 2'd0) begin miscompares++; $display("FAIL reset_rdp: got %0d want 0", bus.mem_Rdp); end
        tick();
        reset = 1'b0;
    endtask

    task automatic test_basic();
        do_reset();
        bus.instr_ready = 1'b1; bus.line_valid = 1'b1; line_data = mkline(32'd1);
        #1;
        vectors++; if (bus.mem_Wr_en !== 1'b1) begin miscompares++; $display("FAIL basic_wr_en: got %b want 1", bus.mem_Wr_en); end
        tick();
        bus.line_valid = 1'b0;
        for (int w = 0; w < 4; w++) begin
            vectors++; if (bus.instr_valid !== 1'b1) begin miscompares++; $display("FAIL basic_valid%0d: got %b want 1", w, bus.instr_valid); end
            vectors++; if (bus.instr !== 32'(w + 1)) begin miscompares++; $display("FAIL basic_instr%0d: got %h want %h", w, bus.instr, 32'(w + 1)); end
            tick();
        end
        vectors++; if (bus.instr_valid !== 1'b0) begin miscompares++; $display("FAIL basic_end_valid: got %b want 0", bus.instr_valid); end
        vectors++; if (bus.level !== 3'd0) begin miscompares++; $display("FAIL basic_end_level: got %0d want 0", bus.level); end
    endtask

    task automatic test_full_stall();
        do_reset();
        fill4(32'd1);
        bus.line_valid = 1'b1; line_data = mkline(32'd17);
        #1;
        vectors++; if (bus.level !== 3'd4) begin miscompares++; $display("FAIL full_level: got %0d want 4", bus.level); end
        vectors++; if (bus.line_ready !== 1'b0) begin miscompares++; $display("FAIL full_line_ready: got %b want 0", bus.line_ready); end
        vectors++; if (bus.mem_Wr_en !== 1'b0) begin miscompares++; $display("FAIL full_wr_en: got %b want 0", bus.mem_Wr_en); end
        for (int i = 0; i < 5; i++) begin
            tick();
            vectors++; if (bus.instr !== 32'h1) begin miscompares++; $display("FAIL stall_instr%0d: got %h want 00000001", i, bus.instr); end
            vectors++; if (bus.mem_Rdp !== 2'd0) begin miscompares++; $display("FAIL stall_rdp%0d: got %0d want 0", i, bus.mem_Rdp); end
        end
        vectors++; if (bus.level !== 3'd4) begin miscompares++; $display("FAIL stall_level: got %0d want 4", bus.level); end
        drain("full");
    endtask

    task automatic test_wrap();
        do_reset();
        fill4(32'd1);
        bus.instr_ready = 1'b1;
        for (int i = 0; i < 16; i++) tick();
        vectors++; if (bus.instr_valid !== 1'b0) begin miscompares++; $display("FAIL wrap_empty: got %b want 0", bus.instr_valid); end
        vectors++; if (bus.mem_Rdp !== 2'd0) begin miscompares++; $display("FAIL wrap_rdp0: got %0d want 0", bus.mem_Rdp); end
        bus.instr_ready = 1'b0; bus.line_valid = 1'b1; line_data = mkline(32'h101);
        #1;
        vectors++; if (bus.mem_Wrp !== 2'd0 || bus.mem_Wr_en !== 1'b1) begin miscompares++; $display("FAIL wrap_wrp0: got wrp=%0d en=%b want 0/1", bus.mem_Wrp, bus.mem_Wr_en); end
        tick();
        line_data = mkline(32'h201);
        #1;
        vectors++; if (bus.mem_Wrp !== 2'd1 || bus.mem_Wr_en !== 1'b1) begin miscompares++; $display("FAIL wrap_wrp1: got wrp=%0d en=%b want 1/1", bus.mem_Wrp, bus.mem_Wr_en); end
        tick();
        bus.line_valid = 1'b0;
        vectors++; if (bus.level !== 3'd2) begin miscompares++; $display("FAIL wrap_level: got %0d want 2", bus.level); end
        vectors++; if (bus.instr !== 32'h101) begin miscompares++; $display("FAIL wrap_instr0: got %h want 00000101", bus.instr); end
        bus.instr_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        vectors++; if (bus.mem_Rdp !== 2'd1) begin miscompares++; $display("FAIL wrap_rdp1: got %0d want 1", bus.mem_Rdp); end
        vectors++; if (bus.instr !== 32'h201) begin miscompares++; $display("FAIL wrap_instr1: got %h want 00000201", bus.instr); end
        drain("wrap");
    endtask

    task automatic test_flush();
        do_reset();
        bus.line_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            line_data = mkline(32'(4 * k + 1));
            tick();
        end
        bus.flush = 1'b1; bus.flush_offset = 2'd2; line_data = mkline(32'd13);
        #1;
        vectors++; if (bus.line_ready !== 1'b0 || bus.mem_Wr_en !== 1'b0) begin miscompares++; $display("FAIL flush_no_write: got rdy=%b en=%b want 0/0", bus.line_ready, bus.mem_Wr_en); end
        tick();
        bus.flush = 1'b0; bus.flush_offset = 2'd0;
        line_data = {32'hD, 32'hC, 32'hB, 32'hA};
        #1;
        vectors++; if (bus.level !== 3'd0) begin miscompares++; $display("FAIL flush_level: got %0d want 0", bus.level); end
        vectors++; if (bus.instr_valid !== 1'b0) begin miscompares++; $display("FAIL flush_valid: got %b want 0", bus.instr_valid); end
        vectors++; if (bus.line_ready !== 1'b1 || bus.mem_Wrp !== 2'd0) begin miscompares++; $display("FAIL flush_ready: got rdy=%b wrp=%0d want 1/0", bus.line_ready, bus.mem_Wrp); end
        tick();
        line_data = mkline(32'h21);
        vectors++; if (bus.instr_valid !== 1'b1 || bus.instr !== 32'hC) begin miscompares++; $display("FAIL flush_instr_c: got v=%b %h want 1/0000000c", bus.instr_valid, bus.instr); end
        bus.instr_ready = 1'b1;
        tick();
        bus.line_valid = 1'b0;
        vectors++; if (bus.instr !== 32'hD) begin miscompares++; $display("FAIL flush_instr_d: got %h want 0000000d", bus.instr); end
        tick();
        vectors++; if (bus.instr !== 32'h21 || bus.mem_Rdp !== 2'd1) begin miscompares++; $display("FAIL flush_next_line: got %h rdp=%0d want 00000021/1", bus.instr, bus.mem_Rdp); end
        drain("flush");
    endtask

    task automatic test_samecycle();
        logic       exp_rdy;
        logic [2:0] exp_lvl;
`ifdef IFQ_SAMECYCLE_EN
        exp_rdy = 1'b1; exp_lvl = 3'd4;
`else
        exp_rdy = 1'b0; exp_lvl = 3'd3;
`endif
        do_reset();
        fill4(32'd1);
        bus.instr_ready = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        bus.line_valid = 1'b1; line_data = mkline(32'd17);
        #1;
        vectors++; if (bus.line_ready !== exp_rdy) begin miscompares++; $display("FAIL same_line_ready: got %b want %b", bus.line_ready, exp_rdy); end
        vectors++; if (bus.mem_Wr_en !== exp_rdy) begin miscompares++; $display("FAIL same_wr_en: got %b want %b", bus.mem_Wr_en, exp_rdy); end
        tick();
        bus.line_valid = 1'b0; bus.instr_ready = 1'b0;
        vectors++; if (bus.level !== exp_lvl) begin miscompares++; $display("FAIL same_level: got %0d want %0d", bus.level, exp_lvl); end
        drain("same");
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 200; i++) begin
            bus.line_valid   = 1'($urandom_range(0, 1));
            bus.instr_ready  = ($urandom_range(0, 3) != 0);
            bus.flush        = ($urandom_range(0, 31) == 0);
            bus.flush_offset = 2'($urandom_range(0, 3));
            line_data        = {$urandom(), $urandom(), $urandom(), $urandom()};
            tick();
        end
        drain("b2b");
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        test_reset();
        test_basic();
        test_full_stall();
        test_wrap();
        test_flush();
        test_samecycle();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/ifq_line_ctrl.md
Name: ifq_line_ctrl

Overview:
- Controller for the 4-entry x 128-bit line buffer `mem`. It sequences `mem` as an instruction fetch queue.
- Accepts 128-bit lines from the fetch side and drives `mem` Wrp/Wr_en/Rdp.
- Unpacks each line into four 32-bit instructions and hands them one at a time to decode/dispatch over a valid/ready handshake.
- Supports flush with a word-offset redirect.

Parameters:
- LINE_W, 128, width of a stored line (must equal 4*WORD_W).
- WORD_W, 32, width of one instruction word.
- PTR_W, 2, `mem` entry pointer width (depth = 2**PTR_W = 4).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- line_valid  input  1  fetch side presents a line this cycle.
- line_ready  output  1  controller accepts the line this cycle.
- mem_Wrp  output  PTR_W  write entry index to `mem`.
- mem_Wr_en  output  1  write strobe to `mem`.
- mem_Rdp  output  PTR_W  read entry index to `mem`.
- mem_dataOut  input  LINE_W  combinational read data from `mem`.
- flush  input  1  discard all queued lines and partial line.
- flush_offset  input  2  word index to start at in first line after flush.
- instr  output  WORD_W  current instruction word.
- instr_valid  output  1  instr holds a valid word.
- instr_ready  input  1  consumer takes instr this cycle.
- level  output  PTR_W+1  number of occupied `mem` entries (0..4).

Behaviour:
- State:
  - wr_ptr and rd_ptr, each PTR_W+1 bits, with the MSB as the wrap bit.
  - word_idx, 2 bits.
  - start_idx, 2 bits: offset for the line currently at the head.
- Reset (async) clears wr_ptr, rd_ptr, word_idx and start_idx to 0. All outputs then read: line_ready=1, mem_Wr_en=0, instr_valid=0, level=0, mem_Wrp=0, mem_Rdp=0.
- Queue flags:
  - empty = (wr_ptr == rd_ptr).
  - full = (low bits equal and MSBs differ).
  - level = wr_ptr - rd_ptr, modulo 2**(PTR_W+1).
- Write side:
  - line_ready = !full && !flush.
  - mem_Wr_en = line_valid && line_ready.
  - mem_Wrp = wr_ptr[PTR_W-1:0].
  - wr_ptr increments on each accepted line.
- Read side:
  - mem_Rdp = rd_ptr[PTR_W-1:0].
  - instr = mem_dataOut[word_idx*WORD_W +: WORD_W]; word 0 is bits [31:0] and word 3 is bits [127:96].
  - instr_valid = !empty.
  - Zero-cycle latency from `mem` read to instr; the stored line is visible the cycle after its write.
- Pop, when instr_valid && instr_ready:
  - If word_idx != 3: word_idx increments.
  - If word_idx == 3: word_idx <= 0, rd_ptr increments and start_idx <= 0.
- Stall: while instr_valid && !instr_ready, instr, word_idx and rd_ptr hold stable.
- Flush has highest priority:
  - The same-cycle write and pop are ignored.
  - wr_ptr <= 0 and rd_ptr <= 0.
  - word_idx <= flush_offset and start_idx <= flush_offset.
  - The next cycle: empty, with line_ready=1.
  - The first line accepted after flush is read starting at word flush_offset; words below it are skipped.
- Simultaneous accept and pop: both pointers update in the same cycle; level is unchanged if the pop completes a line.
- Full + last-word pop: line_ready stays 0 that cycle (no same-cycle refill) unless IFQ_SAMECYCLE_EN is defined.
- Pointer wrap: entry index wraps 3 -> 0; the wrap bit toggles.
- Reset mid-operation: queue contents in `mem` are stale but never presented, because empty gates instr_valid.

Optional Feature:
- Macro: IFQ_SAMECYCLE_EN.
- Defined: line_ready = (!full || (instr_valid && instr_ready && word_idx==3)) && !flush. This allows a write into the freed entry in the same cycle the last word of the head line pops. level stays 4.
- Undefined: line_ready = !full && !flush, as above.

Test Plan:
- Reset then write line 0x00000004_00000003_00000002_00000001 with instr_ready=1 -> next cycles instr = 1, 2, 3, 4, each with instr_valid=1; then instr_valid=0 and level=0.
- Write 4 lines without pops -> level=4, line_ready=0; a 5th line_valid is not accepted (mem_Wr_en=0).
- Hold instr_ready=0 for 5 cycles with a line queued -> instr stays 0x00000001 and mem_Rdp is unchanged.
- Fill 4 lines, pop all 16 words, write 2 more -> mem_Wrp wraps to 0 then 1, and mem_Rdp follows.
- Flush with flush_offset=2 while 3 lines are queued and line_valid=1 -> the next cycle has level=0 and no write. The next line, 0xD_C_B_A, yields instr=0xC then 0xD, then reads from the following entry.
- Full queue, pop word 3 of head with line_valid=1 -> undefined macro: no write that cycle and level=3. IFQ_SAMECYCLE_EN: write accepted and level=4.
